line_fifo_ctrl: RTL

// Pointer/occupancy controller for the BUFFER_SIZE line RAMs sitting between inputCtrl and the interpolation core.
// - Routes inputCtrl writes to one bank.
// - Gives the core the two bank indices holding the top and bottom source lines.
// - Advances the read side on core jmp1/jmp2 and reports line occupancy as fifoNum.

---
 rtl/line_fifo_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/line_fifo_ctrl.sv
// Line RAM bank pointer/occupancy controller between inputCtrl and the interpolation core.
// Optional saturating overflow event counter enabled by defining LFC_OVF_CNT_EN.
module line_fifo_ctrl #(
  parameter int DATA_WIDTH    = 24,
  parameter int ADDRESS_WIDTH = 11,
  parameter int BUFFER_SIZE   = 4,
  parameter int BANK_WIDTH    = 2,
  parameter int CNT_WIDTH     = 3,
  parameter int PRIME_LINES   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wrFrameStart,
  input  logic                     wrFrameEnd,
  input  logic                     wrEn,
  input  logic [ADDRESS_WIDTH-1:0] wrAddr,
  input  logic [DATA_WIDTH-1:0]    wrData,
  input  logic                     wrLineDone,
  input  logic                     jmp1,
  input  logic                     jmp2,
  output logic [BUFFER_SIZE-1:0]   ramWe,
  output logic [ADDRESS_WIDTH-1:0] ramWrAddr,
  output logic [DATA_WIDTH-1:0]    ramWrData,
  output logic [BANK_WIDTH-1:0]    rdSelTop,
  output logic [BANK_WIDTH-1:0]    rdSelBot,
  output logic [CNT_WIDTH-1:0]     fifoNum,
  output logic                     ovf,
  output logic                     udf,
  output logic [15:0]              ovfCnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  localparam logic [CNT_WIDTH-1:0] FULL  = CNT_WIDTH'(BUFFER_SIZE);
  localparam logic [CNT_WIDTH-1:0] PRIME = CNT_WIDTH'(PRIME_LINES);

  logic [1:0]            state_q, state_d;
  logic [BANK_WIDTH-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [BANK_WIDTH-1:0] rdSelTop_q, rdSelBot_q;
  logic [CNT_WIDTH-1:0]  count_q, count_d, fifoNum_q, fifoNum_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic [1:0]            jreq, jeff;
  logic                  w;

  // Pointer advance modulo BUFFER_SIZE; a single subtraction suffices since j <= 2 <= BUFFER_SIZE.
  function automatic logic [BANK_WIDTH-1:0] wrap_add(input logic [BANK_WIDTH-1:0] p,
                                                     input logic [1:0] j);
    logic [BANK_WIDTH+1:0] s;
    s = (BANK_WIDTH+2)'(p) + (BANK_WIDTH+2)'(j);
    if (s >= (BANK_WIDTH+2)'(BUFFER_SIZE)) s = s - (BANK_WIDTH+2)'(BUFFER_SIZE);
    return s[BANK_WIDTH-1:0];
  endfunction

  always_comb begin
    jreq = jmp2 ? 2'd2 : (jmp1 ? 2'd1 : 2'd0);
    if (state_q != RUN) jreq = 2'd0;
    jeff  = jreq;
    udf_d = 1'b0;
    if (CNT_WIDTH'(jreq) > count_q) begin
      jeff  = count_q[1:0];
      udf_d = 1'b1;
    end
    w     = wrLineDone & (state_q != IDLE);
    ovf_d = w & (jeff == 2'd0) & (count_q == FULL);

    wrPtr_d = wrap_add(wrPtr_q, {1'b0, w});
    if (ovf_d) begin
      count_d = count_q;
      rdPtr_d = wrap_add(rdPtr_q, 2'd1);
    end else begin
      count_d = count_q + CNT_WIDTH'(w) - CNT_WIDTH'(jeff);
      rdPtr_d = wrap_add(rdPtr_q, jeff);
    end

    // Transitions look at the post-update count so fifoNum tracks it one cycle after the pulse.
    state_d = state_q;
    case (state_q)
      IDLE:    if (wrFrameStart) state_d = FILL;
      FILL:    if ((count_d >= PRIME) || (wrFrameEnd && (count_d != '0))) state_d = RUN;
      RUN:     if (count_d == '0) state_d = FILL;
      default: state_d = IDLE;
    endcase
    fifoNum_d = (state_d == RUN) ? count_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      fifoNum_q  <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rdSelTop_q <= '0;
      rdSelBot_q <= '0;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      fifoNum_q  <= fifoNum_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rdSelTop_q <= rdPtr_d;
      rdSelBot_q <= wrap_add(rdPtr_d, 2'd1);
    end
  end

  always_comb begin
    ramWe = '0;
    for (int unsigned i = 0; i < BUFFER_SIZE; i++)
      ramWe[i] = wrEn & (state_q != IDLE) & (wrPtr_q == BANK_WIDTH'(i));
  end

`ifdef LFC_OVF_CNT_EN
  logic [15:0] ovfCnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovfCnt_q <= '0;
    else if (ovf_d && (ovfCnt_q != 16'hFFFF)) ovfCnt_q <= ovfCnt_q + 16'd1;
  end
  assign ovfCnt = ovfCnt_q;
`else
  assign ovfCnt = '0;
`endif

  assign ramWrAddr = wrAddr;
  assign ramWrData = wrData;
  assign rdSelTop  = rdSelTop_q;
  assign rdSelBot  = rdSelBot_q;
  assign fifoNum   = fifoNum_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;

endmodule
